// File: rtl/dstack_pkg.sv
// Shared definitions for the data-stack window controller: movement codes,
// controller states and the count width helper.
package dstack_pkg;

  localparam logic [1:0] MOV_HOLD = 2'b00;
  localparam logic [1:0] MOV_PUSH = 2'b01;
  localparam logic [1:0] MOV_POP1 = 2'b10;
  localparam logic [1:0] MOV_POP2 = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPILL = 2'd1,
    FILL  = 2'd2
  } state_t;

  // Wide enough to hold 0..depth inclusive.
  function automatic int countWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dstack_window.sv
// On-chip stack window: DEPTH x WORD_WIDTH shift array applying one core
// command per cycle, plus a bottom-insert port used by memory fills.
import dstack_pkg::*;

module dstack_window #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_apply,
  input  logic [1:0]                 i_movement,
  input  logic                       i_rotate,
  input  logic [4:0]                 i_rotate_addr,
  input  logic [WORD_WIDTH-1:0]      i_next_top,
  input  logic                       i_ins_en,
  input  logic [$clog2(DEPTH)-1:0]   i_ins_idx,
  input  logic [WORD_WIDTH-1:0]      i_ins_data,
  input  logic [$clog2(DEPTH)-1:0]   i_bot_idx,
  output logic [WORD_WIDTH-1:0]      o_top,
  output logic [WORD_WIDTH-1:0]      o_second,
  output logic [WORD_WIDTH-1:0]      o_third,
  output logic [WORD_WIDTH-1:0]      o_rotate_value,
  output logic [WORD_WIDTH-1:0]      o_bottom
);

  logic [WORD_WIDTH-1:0] r_entries [DEPTH];
  logic [WORD_WIDTH-1:0] w_next    [DEPTH];

  // Copy shows up as a push, so rotate only reshapes the array on a hold.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) w_next[i] = r_entries[i];
    if (i_apply) begin
      unique case (i_movement)
        MOV_PUSH: for (int i = 1; i < DEPTH; i++) w_next[i] = r_entries[i-1];
        MOV_POP1: begin
          for (int i = 1; i < DEPTH-1; i++) w_next[i] = r_entries[i+1];
          w_next[DEPTH-1] = '0;
        end
        MOV_POP2: begin
          for (int i = 1; i < DEPTH-2; i++) w_next[i] = r_entries[i+2];
          w_next[DEPTH-2] = '0;
          w_next[DEPTH-1] = '0;
        end
        default: begin
          if (i_rotate) begin
            for (int i = 1; i < DEPTH; i++) begin
              if (i <= int'(i_rotate_addr)) w_next[i] = r_entries[i-1];
            end
          end
        end
      endcase
      w_next[0] = i_next_top;
    end
    if (i_ins_en) w_next[i_ins_idx] = i_ins_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_entries <= '{default: '0};
    else          r_entries <= w_next;
  end

  assign o_top          = r_entries[0];
  assign o_second       = r_entries[1];
  assign o_third        = r_entries[2];
  assign o_rotate_value = r_entries[i_rotate_addr];
  assign o_bottom       = r_entries[i_bot_idx];

endmodule

// File: rtl/dstack_spill_control.sv
// Data-stack window controller: stall logic plus spill/fill of the window bottom.
// Define DSTACK_STATS_EN to add the spill_count/fill_count outputs.
import dstack_pkg::*;

module dstack_spill_control #(
  parameter int                    WORD_WIDTH = 32,
  parameter int                    DEPTH      = 32,
  parameter int                    HIGH_WATER = 28,
  parameter int                    LOW_WATER  = 4,
  parameter logic [WORD_WIDTH-1:0] SPILL_BASE = '0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [1:0]                    movement,
  input  logic [WORD_WIDTH-1:0]         next_top,
  input  logic                          rotate,
  input  logic [4:0]                    rotate_addr,
  output logic [WORD_WIDTH-1:0]         top,
  output logic [WORD_WIDTH-1:0]         second,
  output logic [WORD_WIDTH-1:0]         third,
  output logic [WORD_WIDTH-1:0]         rotate_value,
  output logic                          stall,
  output logic                          underflow,
  output logic [countWidth(DEPTH)-1:0]  count,
  output logic [WORD_WIDTH-1:0]         mem_depth,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [WORD_WIDTH-1:0]         mem_addr,
  output logic [WORD_WIDTH-1:0]         mem_wdata,
  input  logic                          mem_ack,
  input  logic [WORD_WIDTH-1:0]         mem_rdata
`ifdef DSTACK_STATS_EN
  ,
  output logic [WORD_WIDTH-1:0]         spill_count,
  output logic [WORD_WIDTH-1:0]         fill_count
`endif
);

  localparam int CW = countWidth(DEPTH);
  localparam int IW = $clog2(DEPTH);

  state_t                r_state, w_state_next;
  logic [CW-1:0]         r_count, w_count_cmd, w_count_next;
  logic [WORD_WIDTH-1:0] r_mem_depth, w_depth_next;
  logic                  r_underflow, w_underflow_next;
  logic                  r_mem_req, r_mem_we, w_req_next, w_we_next;
  logic [WORD_WIDTH-1:0] r_mem_addr, r_mem_wdata, w_addr_next, w_wdata_next;
  logic [WORD_WIDTH-1:0] w_bottom;
  logic                  w_is_push, w_uses_k, w_has_mem, w_ins_en;
  logic [1:0]            w_pop_n;
  logic [CW-1:0]         w_pop_cw, w_k_cw;

  assign w_is_push = (movement == MOV_PUSH);
  assign w_pop_n   = (movement == MOV_POP1) ? 2'd1 : (movement == MOV_POP2) ? 2'd2 : 2'd0;
  assign w_pop_cw  = CW'(w_pop_n);
  assign w_k_cw    = CW'(rotate_addr);
  // A copy is a push with rotate set; both it and a rotate read entry[rotate_addr].
  assign w_uses_k  = rotate && (movement == MOV_HOLD || movement == MOV_PUSH);
  assign w_has_mem = (r_mem_depth != '0);

  assign stall = (w_is_push && r_count == CW'(DEPTH))
              || (w_pop_n != 2'd0 && r_count < w_pop_cw + 1'b1 && w_has_mem)
              || (w_uses_k && w_k_cw >= r_count && w_has_mem)
              || (w_uses_k && w_k_cw + 1'b1 >= r_count && r_state == SPILL);

  always_comb begin
    w_count_cmd      = r_count;
    w_underflow_next = r_underflow;
    if (!stall) begin
      if (w_is_push) begin
        w_count_cmd = r_count + 1'b1;
      end else if (w_pop_n != 2'd0) begin
        if (w_pop_cw > r_count) begin
          w_count_cmd      = '0;
          w_underflow_next = 1'b1;
        end else begin
          w_count_cmd = r_count - w_pop_cw;
        end
      end
    end
  end

  // Memory acks adjust the count on top of whatever the core did this cycle.
  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_mem_req;
    w_we_next    = r_mem_we;
    w_addr_next  = r_mem_addr;
    w_wdata_next = r_mem_wdata;
    w_count_next = w_count_cmd;
    w_depth_next = r_mem_depth;
    w_ins_en     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_count > CW'(HIGH_WATER)) begin
          w_state_next = SPILL;
          w_req_next   = 1'b1;
          w_we_next    = 1'b1;
          w_addr_next  = SPILL_BASE + r_mem_depth;
          w_wdata_next = w_bottom;
        end else if (r_count < CW'(LOW_WATER) && w_has_mem) begin
          w_state_next = FILL;
          w_req_next   = 1'b1;
          w_we_next    = 1'b0;
          w_addr_next  = SPILL_BASE + r_mem_depth - 1'b1;
        end
      end
      SPILL: begin
        if (mem_ack) begin
          w_state_next = IDLE;
          w_req_next   = 1'b0;
          w_we_next    = 1'b0;
          w_depth_next = r_mem_depth + 1'b1;
          w_count_next = (w_count_cmd == '0) ? '0 : w_count_cmd - 1'b1;
        end
      end
      FILL: begin
        if (mem_ack) begin
          w_state_next = IDLE;
          w_req_next   = 1'b0;
          w_we_next    = 1'b0;
          w_ins_en     = (w_count_cmd < CW'(DEPTH));
          w_depth_next = r_mem_depth - 1'b1;
          w_count_next = w_count_cmd + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_mem_depth <= '0;
      r_underflow <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_mem_depth <= w_depth_next;
      r_underflow <= w_underflow_next;
      r_mem_req   <= w_req_next;
      r_mem_we    <= w_we_next;
      r_mem_addr  <= w_addr_next;
      r_mem_wdata <= w_wdata_next;
    end
  end

  dstack_window #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH)
  ) u_window (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_apply        (!stall),
    .i_movement     (movement),
    .i_rotate       (rotate),
    .i_rotate_addr  (rotate_addr),
    .i_next_top     (next_top),
    .i_ins_en       (w_ins_en),
    .i_ins_idx      (IW'(w_count_cmd)),
    .i_ins_data     (mem_rdata),
    .i_bot_idx      (IW'(r_count - 1'b1)),
    .o_top          (top),
    .o_second       (second),
    .o_third        (third),
    .o_rotate_value (rotate_value),
    .o_bottom       (w_bottom)
  );

  assign count     = r_count;
  assign mem_depth = r_mem_depth;
  assign underflow = r_underflow;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

`ifdef DSTACK_STATS_EN
  logic [WORD_WIDTH-1:0] r_spill_count, r_fill_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_spill_count <= '0;
      r_fill_count  <= '0;
    end else begin
      if (r_state == SPILL && mem_ack) r_spill_count <= r_spill_count + 1'b1;
      if (r_state == FILL && mem_ack)  r_fill_count  <= r_fill_count + 1'b1;
    end
  end

  assign spill_count = r_spill_count;
  assign fill_count  = r_fill_count;
`endif

endmodule

// File: tb/tb_dstack_spill_control.sv
// Bench for dstack_spill_control: an independent reference model fills a
// scoreboard queue per driven command, compared against the DUT after the edge.
module tb_dstack_spill_control;
  import dstack_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  movement;
  logic [31:0] next_top;
  logic        rotate;
  logic [4:0]  rotate_addr;
  logic [31:0] top, second, third, rotate_value;
  logic        stall, underflow;
  logic [5:0]  count;
  logic [31:0] mem_depth;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dstack_spill_control dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .movement     (movement),
    .next_top     (next_top),
    .rotate       (rotate),
    .rotate_addr  (rotate_addr),
    .top          (top),
    .second       (second),
    .third        (third),
    .rotate_value (rotate_value),
    .stall        (stall),
    .underflow    (underflow),
    .count        (count),
    .mem_depth    (mem_depth),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  typedef struct {
    logic [31:0] top, second, third;
    int          count, depth;
    bit          under, req, we;
    logic [31:0] addr, wdata;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: mState 0 = idle, 1 = spill, 2 = fill.
  logic [31:0] mE [32];
  int          mCount, mDepth, mState;
  bit          mUnder, mReq, mWe;
  logic [31:0] mAddr, mWdata;
  logic [31:0] memArr [256];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit modelStall(input logic [1:0] mov, input bit rot, input logic [4:0] k);
    int  n;
    bit  usesK;
    n     = (mov == MOV_POP1) ? 1 : (mov == MOV_POP2) ? 2 : 0;
    usesK = rot && (mov == MOV_HOLD || mov == MOV_PUSH);
    return (mov == MOV_PUSH && mCount == 32)
        || (n > 0 && mCount - n < 1 && mDepth > 0)
        || (usesK && int'(k) >= mCount && mDepth > 0)
        || (usesK && int'(k) >= mCount - 1 && mState == 1);
  endfunction

  task automatic modelAdvance(input logic [1:0] mov, input logic [31:0] nt, input bit rot,
                              input logic [4:0] k, input bit ack, input logic [31:0] rdata,
                              input bit stl);
    logic [31:0] nE [32];
    int c, oldC, n;
    nE   = mE;
    c    = mCount;
    oldC = mCount;
    if (!stl) begin
      if (mov == MOV_PUSH) begin
        for (int i = 31; i > 0; i--) nE[i] = mE[i-1];
        c++;
      end else if (mov == MOV_POP1 || mov == MOV_POP2) begin
        n = (mov == MOV_POP1) ? 1 : 2;
        if (n > c) mUnder = 1'b1;
        for (int i = 1; i < 32; i++) begin
          if (i + n < 32) nE[i] = mE[i+n];
          else            nE[i] = '0;
        end
        c = (c > n) ? c - n : 0;
      end else if (rot) begin
        for (int i = 1; i <= int'(k); i++) nE[i] = mE[i-1];
      end
      nE[0] = nt;
    end
    if (mState == 0) begin
      if (oldC > 28) begin
        mState = 1; mReq = 1'b1; mWe = 1'b1; mAddr = mDepth; mWdata = mE[oldC-1];
      end else if (oldC < 4 && mDepth > 0) begin
        mState = 2; mReq = 1'b1; mWe = 1'b0; mAddr = mDepth - 1;
      end
    end else if (ack) begin
      if (mState == 1) begin
        memArr[mAddr[7:0]] = mWdata;
        mDepth++;
        c = (c > 0) ? c - 1 : 0;
      end else begin
        if (c < 32) nE[c] = rdata;
        c++;
        mDepth--;
      end
      mState = 0; mReq = 1'b0; mWe = 1'b0;
    end
    mE     = nE;
    mCount = c;
  endtask

  task automatic applyStimulus(input logic [1:0] mov, input logic [31:0] nt, input bit rot,
                               input logic [4:0] k, input bit ack);
    exp_t e;
    bit   expStall;
    @(negedge clk);
    movement    = mov;
    next_top    = nt;
    rotate      = rot;
    rotate_addr = k;
    mem_ack     = ack;
    mem_rdata   = memArr[mAddr[7:0]];
    #1;
    expStall = modelStall(mov, rot, k);
    checkOutput("stall", 32'(stall), 32'(expStall));
    if (int'(k) < mCount) checkOutput("rotate_value", rotate_value, mE[k]);
    modelAdvance(mov, nt, rot, k, ack, mem_rdata, expStall);
    e.top = mE[0]; e.second = mE[1]; e.third = mE[2];
    e.count = mCount; e.depth = mDepth; e.under = mUnder;
    e.req = mReq; e.we = mWe; e.addr = mAddr; e.wdata = mWdata;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    e = sbQ.pop_front();
    checkOutput("top", top, e.top);
    if (e.count > 1) checkOutput("second", second, e.second);
    if (e.count > 2) checkOutput("third", third, e.third);
    checkOutput("count", 32'(count), e.count);
    checkOutput("mem_depth", mem_depth, e.depth);
    checkOutput("underflow", 32'(underflow), 32'(e.under));
    checkOutput("mem_req", 32'(mem_req), 32'(e.req));
    if (e.req) begin
      checkOutput("mem_we", 32'(mem_we), 32'(e.we));
      checkOutput("mem_addr", mem_addr, e.addr);
      if (e.we) checkOutput("mem_wdata", mem_wdata, e.wdata);
    end
  endtask

  task automatic holdTop(input bit ack);
    applyStimulus(MOV_HOLD, mE[0], 1'b0, 5'd0, ack);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0; movement = MOV_HOLD; next_top = '0; rotate = 1'b0; mem_ack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_mem_depth", mem_depth, 32'd0);
    checkOutput("rst_underflow", 32'(underflow), 32'd0);
    checkOutput("rst_top", top, 32'd0);
    for (int i = 0; i < 32; i++) mE[i] = '0;
    mCount = 0; mDepth = 0; mState = 0; mUnder = 1'b0;
    mReq = 1'b0; mWe = 1'b0; mAddr = '0; mWdata = '0;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; movement = MOV_HOLD; next_top = '0; rotate = 1'b0;
    rotate_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
    mAddr = '0;
    for (int i = 0; i < 256; i++) memArr[i] = '0;
    doReset();

    // Spill of the bottom element once the window passes the high mark.
    for (int v = 1; v <= 29; v++) applyStimulus(MOV_PUSH, 32'(v), 1'b0, 5'd0, 1'b0);
    holdTop(1'b0);
    checkOutput("spill_req", 32'(mem_req), 32'd1);
    checkOutput("spill_we", 32'(mem_we), 32'd1);
    checkOutput("spill_addr", mem_addr, 32'd0);
    checkOutput("spill_wdata", mem_wdata, 32'd1);
    holdTop(1'b0);
    holdTop(1'b1);
    checkOutput("spill_count", 32'(count), 32'd28);
    checkOutput("spill_depth", mem_depth, 32'd1);

    // Fill back once the window drops below the low mark.
    for (int i = 0; i < 40 && mCount > 3; i++) applyStimulus(MOV_POP1, mE[1], 1'b0, 5'd0, 1'b0);
    checkOutput("fill_pre_count", 32'(count), 32'd3);
    holdTop(1'b0);
    checkOutput("fill_req", 32'(mem_req), 32'd1);
    checkOutput("fill_we", 32'(mem_we), 32'd0);
    checkOutput("fill_addr", mem_addr, 32'd0);
    applyStimulus(MOV_HOLD, mE[0], 1'b0, 5'd3, 1'b1);
    checkOutput("fill_count", 32'(count), 32'd4);
    checkOutput("fill_depth", mem_depth, 32'd0);
    checkOutput("fill_e3", rotate_value, 32'd1);

    // Push into a full window while the spill is still waiting.
    for (int i = 0; i < 40 && mCount < 32; i++) applyStimulus(MOV_PUSH, 32'h100 + 32'(i), 1'b0, 5'd0, 1'b0);
    checkOutput("full_count", 32'(count), 32'd32);
    applyStimulus(MOV_PUSH, 32'hAA, 1'b0, 5'd0, 1'b0);
    checkOutput("full_stall", 32'(stall), 32'd1);
    checkOutput("full_top_kept", top, 32'h11B);
    applyStimulus(MOV_PUSH, 32'hAA, 1'b0, 5'd0, 1'b1);
    checkOutput("full_ack_count", 32'(count), 32'd31);
    checkOutput("full_ack_top", top, 32'h11B);
    applyStimulus(MOV_PUSH, 32'hAA, 1'b0, 5'd0, 1'b0);
    checkOutput("full_push_top", top, 32'hAA);
    checkOutput("full_push_count", 32'(count), 32'd32);
    checkOutput("respill_req", 32'(mem_req), 32'd1);
    doReset();

    // Rotate, copy and underflow on a small stack.
    applyStimulus(MOV_PUSH, 32'hD, 1'b0, 5'd0, 1'b0);
    applyStimulus(MOV_PUSH, 32'hC, 1'b0, 5'd0, 1'b0);
    applyStimulus(MOV_PUSH, 32'hB, 1'b0, 5'd0, 1'b0);
    applyStimulus(MOV_PUSH, 32'hA, 1'b0, 5'd0, 1'b0);
    applyStimulus(MOV_HOLD, 32'hC, 1'b1, 5'd2, 1'b0);
    checkOutput("rot_top", top, 32'hC);
    checkOutput("rot_second", second, 32'hA);
    checkOutput("rot_third", third, 32'hB);
    checkOutput("rot_e2", rotate_value, 32'hB);
    applyStimulus(MOV_PUSH, mE[3], 1'b1, 5'd3, 1'b0);
    checkOutput("copy_top", top, 32'hD);
    checkOutput("copy_count", 32'(count), 32'd5);
    applyStimulus(MOV_POP2, mE[2], 1'b0, 5'd0, 1'b0);
    applyStimulus(MOV_POP2, mE[2], 1'b0, 5'd0, 1'b0);
    checkOutput("pre_under_count", 32'(count), 32'd1);
    applyStimulus(MOV_POP2, 32'h55, 1'b0, 5'd0, 1'b0);
    checkOutput("under_flag", 32'(underflow), 32'd1);
    checkOutput("under_count", 32'(count), 32'd0);
    checkOutput("under_top", top, 32'h55);
    doReset();

    // Random traffic: a push-heavy phase to spill, then a pop-heavy phase to fill.
    for (int phase = 0; phase < 2; phase++) begin
      for (int s = 0; s < 300; s++) begin
        int r;
        logic [1:0] mov;
        r = $urandom_range(0, 9);
        if (phase == 0) mov = (r < 5) ? MOV_PUSH : (r < 7) ? MOV_POP1 : (r < 8) ? MOV_POP2 : MOV_HOLD;
        else            mov = (r < 2) ? MOV_PUSH : (r < 5) ? MOV_POP1 : (r < 7) ? MOV_POP2 : MOV_HOLD;
        applyStimulus(mov, $urandom, ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dstack_spill_control.md
Name: dstack_spill_control

Overview:
- Owns the on-chip data-stack window that feeds top/second/third and rotate_value to the instruction decode and ALU path.
- Applies the per-cycle movement, next_top and rotate commands issued by the stack-control decode.
- Spills the bottom of the window to memory when the window runs high, and fills it back from memory when the window runs low.
- Asserts stall, which feeds the core halt, whenever a command cannot be applied this cycle.

Parameters:
- WORD_WIDTH, 32, data word width.
- DEPTH, 32, on-chip entries; must be >= 32 so every rotate_addr is addressable.
- HIGH_WATER, 28, spill starts when count > HIGH_WATER; must be < DEPTH.
- LOW_WATER, 4, fill starts when count < LOW_WATER and mem_depth > 0; must satisfy 3 <= LOW_WATER < HIGH_WATER.
- SPILL_BASE, 0, memory word address of spilled stack element 0.

Ports:
- clk, in, 1: the single clock.
- reset_n, in, 1: synchronous, active-low reset.
- movement, in, 2: 00 hold, 01 push, 10 pop1, 11 pop2.
- next_top, in, WORD_WIDTH: new value of entry 0.
- rotate, in, 1: rotate command.
- rotate_addr, in, 5: depth k used by rotate and copy.
- top, second, third, out, WORD_WIDTH: entries 0, 1 and 2.
- rotate_value, out, WORD_WIDTH: combinational entry[rotate_addr].
- stall, out, 1: combinational; command is not applied this cycle.
- underflow, out, 1: sticky error flag.
- count, out, 6: number of valid on-chip entries.
- mem_depth, out, WORD_WIDTH: number of spilled entries.
- mem_req, out, 1; mem_we, out, 1; mem_addr, out, WORD_WIDTH; mem_wdata, out, WORD_WIDTH.
- mem_ack, in, 1; mem_rdata, in, WORD_WIDTH: read data is valid with mem_ack.

Behaviour:
- Reset (reset_n low at a rising edge): all entries = 0, count = 0, mem_depth = 0, underflow = 0, FSM = IDLE, mem_req = 0. Reset aborts any outstanding memory request; the memory side tolerates a dropped request.
- Entry array update, applied at the edge when stall = 0, with E' the new array and E the old:
  - hold: E'[0] = next_top; all other entries unchanged.
  - push: E'[0] = next_top; E'[i] = E[i-1]; count + 1.
  - pop1: E'[0] = next_top; E'[i] = E[i+1] for i >= 1; count - 1.
  - pop2: E'[0] = next_top; E'[i] = E[i+2] for i >= 1; count - 2.
  - rotate with movement = 00: E'[0] = next_top; E'[i] = E[i-1] for 1 <= i <= k; entries deeper than k unchanged; count unchanged.
  - Copy arrives as a push whose next_top = rotate_value.
- Stall conditions (any one asserts stall):
  - push while count == DEPTH;
  - pop n while count - n < 1 and mem_depth > 0;
  - rotate or copy while rotate_addr >= count and mem_depth > 0;
  - rotate or copy while rotate_addr >= count - 1 and FSM == SPILL.
- While stalled, array, count and underflow are unchanged; the core re-presents the same command.
- Underflow: pop n with n > count and mem_depth == 0 sets underflow = 1. count saturates at 0 and E'[0] = next_top.
- FSM states: IDLE, SPILL, FILL.
  - IDLE -> SPILL when count > HIGH_WATER. Latch mem_addr = SPILL_BASE + mem_depth and mem_wdata = E[count-1]; mem_we = 1; mem_req = 1.
  - IDLE -> FILL when count < LOW_WATER and mem_depth > 0. mem_addr = SPILL_BASE + mem_depth - 1; mem_we = 0; mem_req = 1.
  - The two watermarks are disjoint, so SPILL and FILL are never both requested.
  - mem_req, mem_we, mem_addr and mem_wdata are registered and held stable until mem_ack.
  - SPILL + mem_ack: mem_depth + 1; count = count' - 1, where count' is the count after the same-cycle core command. Go to IDLE.
  - FILL + mem_ack: E'[count'] = mem_rdata; count = count' + 1; mem_depth - 1. Go to IDLE.
  - mem_req = 0 in the cycle after mem_ack, giving at least one idle cycle between memory requests.
- Core commands keep being accepted during SPILL and FILL, subject to the stall rules above.
- Latency: 0 from command to output update (outputs change at the next edge). Spill and fill latency = 1 cycle + memory wait.
- The spilled bottom element keeps its identity during SPILL because count > HIGH_WATER >= 4 and deep rotates are stalled.

Optional Feature:
- Macro DSTACK_STATS_EN.
- When defined: adds outputs spill_count and fill_count, each WORD_WIDTH wide, reset to 0, incremented on each spill ack and fill ack respectively, wrapping modulo 2^WORD_WIDTH.
- When undefined: these ports and counters are absent and there is no other behavioural change.

Decomposition:
- Package dstack_pkg holds:
  - movement constants MOV_HOLD, MOV_PUSH, MOV_POP1, MOV_POP2;
  - the FSM state enum (IDLE, SPILL, FILL);
  - a count width function of DEPTH.
- Sub-module dstack_window: the DEPTH x WORD_WIDTH shift-array, the command application and the bottom-insert port.
- The FSM, stall logic and memory interface stay in the top module.

Test Plan:
- Reset: hold reset_n low 2 cycles mid-SPILL -> mem_req = 0, count = 0, mem_depth = 0 and underflow = 0 after the edge.
- Spill: push values 1..29 -> at count 29, mem_req = 1, mem_we = 1, mem_addr = 0, mem_wdata = 1. Ack 2 cycles later -> count = 28, mem_depth = 1.
- Fill: continuing from Spill, pop1 until count = 3 -> read at mem_addr = 0; mem_rdata = 1 with ack -> E[3] = 1, count = 4, mem_depth = 0.
- Full stall: count = 32 with mem_ack held low, push 0xAA -> stall = 1 and the array is unchanged. After ack -> count = 31, then the push is applied with top = 0xAA.
- Rotate: stack [A,B,C,D], rotate = 1, rotate_addr = 2, next_top = C -> [C,A,B,D].
- Underflow: count = 1, mem_depth = 0, pop2 -> underflow = 1, count = 0, top = next_top.
